// File: rtl/pcie_tx_arbiter_pkg.sv
// Shared definitions for the PCIe TX arbiter: FSM state encodings and
// source port indices. Optional build macro used by this slice:
// COMPL_PRIORITY_EN (strict completion priority instead of round-robin).
package pcie_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT0    = 2'd1,
        GNT1    = 2'd2,
        TURNOFF = 2'd3
    } arb_state_t;

    // Port 0 carries PIO read completions, port 1 carries memory-write requests.
    localparam logic PORT_CPL = 1'b0;
    localparam logic PORT_REQ = 1'b1;

    // Grant state that corresponds to a picked port.
    function automatic arb_state_t gnt_state(input logic port);
        return (port == PORT_REQ) ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/pcie_tx_arbiter_rr_pick2.sv
// Two-requester pick logic for the PCIe TX arbiter.
// Default: round-robin against last_grant. With COMPL_PRIORITY_EN defined,
// port 0 (completions) wins whenever it is requesting.
module rr_pick2
    import pcie_tx_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       pick,
    output logic       any
);

`ifdef COMPL_PRIORITY_EN
    // Priority build does not look at history.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Completions first; requester only when completer is silent.
    always_comb begin
        any  = |valid;
        pick = valid[PORT_CPL] ? PORT_CPL : PORT_REQ;
    end
`else
    // Contention goes to the port not served last; a lone requester just wins.
    always_comb begin
        any = |valid;
        if (&valid)
            pick = ~last_grant;
        else
            pick = valid[PORT_REQ];
    end
`endif

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular arbiter sharing the PCIe AXIS TX port between the PIO
// completer (port 0) and requester (port 1). Grant is locked from the first
// beat to tlast; an idle bubble separates packets. Also owns the
// cfg_to_turnoff / cfg_turnoff_ok handshake.
// Build macro: COMPL_PRIORITY_EN selects strict completion priority.
module pcie_tx_arbiter #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                  user_clk,
    input  logic                  sys_rst_n,
    input  logic                  user_lnk_up,
    input  logic [DATA_W-1:0]     in0_tdata,
    input  logic [DATA_W/8-1:0]   in0_tkeep,
    input  logic                  in0_tlast,
    input  logic                  in0_tvalid,
    output logic                  in0_tready,
    input  logic [DATA_W-1:0]     in1_tdata,
    input  logic [DATA_W/8-1:0]   in1_tkeep,
    input  logic                  in1_tlast,
    input  logic                  in1_tvalid,
    output logic                  in1_tready,
    output logic [DATA_W-1:0]     s_axis_tx_tdata,
    output logic [DATA_W/8-1:0]   s_axis_tx_tkeep,
    output logic                  s_axis_tx_tlast,
    output logic                  s_axis_tx_tvalid,
    input  logic                  s_axis_tx_tready,
    output logic                  tx_src_dsc,
    input  logic                  cfg_to_turnoff,
    output logic                  cfg_turnoff_ok,
    output logic [CNT_W-1:0]      pkt_cnt0,
    output logic [CNT_W-1:0]      pkt_cnt1
);
    import pcie_tx_arbiter_pkg::*;

    arb_state_t state;
    logic       last_grant;
    logic       pick;
    logic       any_valid;

    rr_pick2 u_pick (
        .valid      ({in1_tvalid, in0_tvalid}),
        .last_grant (last_grant),
        .pick       (pick),
        .any        (any_valid)
    );

    // Packets are never cut short, so discontinue is never signalled.
    assign tx_src_dsc = 1'b0;

    // Grant FSM, turnoff acknowledge and per-port packet counters.
    always_ff @(posedge user_clk) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            last_grant     <= PORT_REQ;
            cfg_turnoff_ok <= 1'b0;
            pkt_cnt0       <= '0;
            pkt_cnt1       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_to_turnoff) begin
                        state          <= TURNOFF;
                        cfg_turnoff_ok <= 1'b1;
                    end else if (user_lnk_up && any_valid) begin
                        state      <= gnt_state(pick);
                        last_grant <= pick;
                    end
                end
                GNT0: begin
                    if (in0_tvalid && s_axis_tx_tready && in0_tlast) begin
                        state    <= IDLE;
                        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
                    end
                end
                GNT1: begin
                    if (in1_tvalid && s_axis_tx_tready && in1_tlast) begin
                        state    <= IDLE;
                        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
                    end
                end
                TURNOFF: begin
                    if (!cfg_to_turnoff) begin
                        state          <= IDLE;
                        cfg_turnoff_ok <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency mux of the granted source; everything idles outside a grant.
    always_comb begin
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tvalid = 1'b0;
        in0_tready       = 1'b0;
        in1_tready       = 1'b0;
        case (state)
            GNT0: begin
                s_axis_tx_tdata  = in0_tdata;
                s_axis_tx_tkeep  = in0_tkeep;
                s_axis_tx_tlast  = in0_tlast;
                s_axis_tx_tvalid = in0_tvalid;
                in0_tready       = s_axis_tx_tready;
            end
            GNT1: begin
                s_axis_tx_tdata  = in1_tdata;
                s_axis_tx_tkeep  = in1_tkeep;
                s_axis_tx_tlast  = in1_tlast;
                s_axis_tx_tvalid = in1_tvalid;
                in1_tready       = s_axis_tx_tready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Self-checking bench for pcie_tx_arbiter: queue-driven AXIS sources, a
// packet-level reference model compared every cycle, and directed scenarios
// with hand-computed expectations. Counters are built 4 bits wide so the
// wrap case is reachable in a few packets.
module tb_pcie_tx_arbiter;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 4;
    localparam int CMOD   = 16;

    logic              user_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              user_lnk_up = 1'b1;
    logic [DATA_W-1:0] in0_tdata = '0, in1_tdata = '0;
    logic [KEEP_W-1:0] in0_tkeep = '0, in1_tkeep = '0;
    logic              in0_tlast = 1'b0, in1_tlast = 1'b0;
    logic              in0_tvalid = 1'b0, in1_tvalid = 1'b0;
    logic              in0_tready, in1_tready;
    logic [DATA_W-1:0] s_axis_tx_tdata;
    logic [KEEP_W-1:0] s_axis_tx_tkeep;
    logic              s_axis_tx_tlast, s_axis_tx_tvalid;
    logic              s_axis_tx_tready = 1'b1;
    logic              tx_src_dsc;
    logic              cfg_to_turnoff = 1'b0;
    logic              cfg_turnoff_ok;
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

    pcie_tx_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .user_clk(user_clk), .sys_rst_n(sys_rst_n), .user_lnk_up(user_lnk_up),
        .in0_tdata(in0_tdata), .in0_tkeep(in0_tkeep), .in0_tlast(in0_tlast),
        .in0_tvalid(in0_tvalid), .in0_tready(in0_tready),
        .in1_tdata(in1_tdata), .in1_tkeep(in1_tkeep), .in1_tlast(in1_tlast),
        .in1_tvalid(in1_tvalid), .in1_tready(in1_tready),
        .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
        .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tvalid(s_axis_tx_tvalid),
        .s_axis_tx_tready(s_axis_tx_tready), .tx_src_dsc(tx_src_dsc),
        .cfg_to_turnoff(cfg_to_turnoff), .cfg_turnoff_ok(cfg_turnoff_ok),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #2 user_clk = ~user_clk;

    typedef struct { logic [DATA_W-1:0] data; logic [KEEP_W-1:0] keep; logic last; } beat_t;
    typedef struct { int cyc; beat_t b; } obs_t;

    beat_t q0[$], q1[$];
    obs_t  log_q[$];
    int    cyc = 0;
    int    n_checks = 0, n_fail = 0;
    int    tready_mode = 0;
    logic  acc0 = 1'b0, acc1 = 1'b0;
    int    t0_start = -1, ok_rise = -1, in0_rdy_seen = 0, stalls = 0;

    // reference model: owner -1 = nobody, 0/1 = port, 2 = turnoff
    int    m_owner = -1, m_last = 1, m_cnt0 = 0, m_cnt1 = 0;
    bit    m_ok = 1'b0;

    logic [DATA_W-1:0] e_data;
    logic [KEEP_W-1:0] e_keep;
    logic              e_last, e_valid;
    logic [1:0]        e_rdy;

    function automatic logic [DATA_W-1:0] bdat(int p, int id, int b);
        return {8'(p), 8'(id), 8'(b), 40'h5A5A5A5A5A};
    endfunction

    function automatic int winner(logic v0, logic v1, int last);
`ifdef COMPL_PRIORITY_EN
        return v0 ? 0 : 1;
`else
        if (v0 && v1) return 1 - last;
        return v0 ? 0 : 1;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic push_pkt(input int p, input int id, input int nb);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.data = bdat(p, id, i);
            b.last = (i == nb - 1);
            b.keep = b.last ? 8'h0F : 8'hFF;
            if (p == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic wait_log(input int n, input int max, input string nm);
        int k = 0;
        while (log_q.size() < n && k < max) begin
            @(posedge user_clk);
            k++;
        end
        #1;
        if (log_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d beats expected %0d", nm, log_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(posedge user_clk); #1;
        sys_rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge user_clk);
        #1;
        sys_rst_n = 1'b1;
        log_q.delete();
        t0_start = -1;
        ok_rise  = -1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge user_clk);
        #1;
    endtask

    always @(posedge user_clk) cyc <= cyc + 1;

    // Packet-level reference model of the arbiter.
    always @(posedge user_clk) begin
        if (!sys_rst_n) begin
            m_owner <= -1; m_last <= 1; m_cnt0 <= 0; m_cnt1 <= 0; m_ok <= 1'b0;
        end else if (m_owner == -1) begin
            if (cfg_to_turnoff) begin
                m_owner <= 2; m_ok <= 1'b1;
            end else if (user_lnk_up && (in0_tvalid || in1_tvalid)) begin
                m_owner <= winner(in0_tvalid, in1_tvalid, m_last);
                m_last  <= winner(in0_tvalid, in1_tvalid, m_last);
            end
        end else if (m_owner == 0) begin
            if (in0_tvalid && s_axis_tx_tready && in0_tlast) begin
                m_owner <= -1; m_cnt0 <= (m_cnt0 + 1) % CMOD;
            end
        end else if (m_owner == 1) begin
            if (in1_tvalid && s_axis_tx_tready && in1_tlast) begin
                m_owner <= -1; m_cnt1 <= (m_cnt1 + 1) % CMOD;
            end
        end else if (!cfg_to_turnoff) begin
            m_owner <= -1; m_ok <= 1'b0;
        end
    end

    // Source / sink driver: pops accepted beats and presents the next head.
    initial begin
        forever begin
            @(posedge user_clk); #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            in0_tvalid = (q0.size() > 0);
            in0_tdata  = in0_tvalid ? q0[0].data : '0;
            in0_tkeep  = in0_tvalid ? q0[0].keep : '0;
            in0_tlast  = in0_tvalid ? q0[0].last : 1'b0;
            in1_tvalid = (q1.size() > 0);
            in1_tdata  = in1_tvalid ? q1[0].data : '0;
            in1_tkeep  = in1_tvalid ? q1[0].keep : '0;
            in1_tlast  = in1_tvalid ? q1[0].last : 1'b0;
            s_axis_tx_tready = (tready_mode == 1) ? ~s_axis_tx_tready : 1'b1;
        end
    end

    // Monitor and per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge user_clk);
            acc0 = in0_tvalid && in0_tready;
            acc1 = in1_tvalid && in1_tready;
            if (s_axis_tx_tvalid && s_axis_tx_tready)
                log_q.push_back('{cyc, '{s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast}});
            if (in0_tvalid && t0_start < 0) t0_start = cyc;
            if (cfg_turnoff_ok && ok_rise < 0) ok_rise = cyc;
            if (in0_tready) in0_rdy_seen++;
            if (s_axis_tx_tvalid && !s_axis_tx_tready) stalls++;
            if (cyc > 0) begin
                e_data = '0; e_keep = '0; e_last = 1'b0; e_valid = 1'b0; e_rdy = 2'b00;
                if (m_owner == 0) begin
                    e_data = in0_tdata; e_keep = in0_tkeep; e_last = in0_tlast;
                    e_valid = in0_tvalid; e_rdy = {1'b0, s_axis_tx_tready};
                end else if (m_owner == 1) begin
                    e_data = in1_tdata; e_keep = in1_tkeep; e_last = in1_tlast;
                    e_valid = in1_tvalid; e_rdy = {s_axis_tx_tready, 1'b0};
                end
                check("cyc_tdata", s_axis_tx_tdata, e_data);
                check("cyc_ctl", {s_axis_tx_tvalid, s_axis_tx_tlast, s_axis_tx_tkeep},
                      {e_valid, e_last, e_keep});
                check("cyc_tready", {in1_tready, in0_tready}, e_rdy);
                check("cyc_turnoff_ok", cfg_turnoff_ok, m_ok);
                check("cyc_counters", {pkt_cnt1, pkt_cnt0}, {CNT_W'(m_cnt1), CNT_W'(m_cnt0)});
                check("cyc_dsc", tx_src_dsc, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int exp_ord[4];
        int last_cyc;

        // reset state
        do_reset();
        @(negedge user_clk);
        check("rst_tvalid", s_axis_tx_tvalid, 1'b0);
        check("rst_tready", {in1_tready, in0_tready}, 2'b00);
        check("rst_ok", cfg_turnoff_ok, 1'b0);
        check("rst_cnt", {pkt_cnt1, pkt_cnt0}, 8'h00);

        // T1: single 3-beat TLP on port 0
        do_reset();
        push_pkt(0, 1, 3);
        wait_log(3, 50, "t1_wait");
        settle(2);
        check("t1_nbeats", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            check("t1_bubble", log_q[0].cyc - t0_start, 1);
            for (int i = 0; i < 3; i++) begin
                check("t1_cycle", log_q[i].cyc - log_q[0].cyc, i);
                check("t1_data", log_q[i].b.data, bdat(0, 1, i));
                check("t1_last", log_q[i].b.last, (i == 2));
            end
        end
        check("t1_cnt0", pkt_cnt0, 4'd1);

        // T2: both ports busy with 2-beat TLPs
        do_reset();
        push_pkt(0, 1, 2); push_pkt(0, 2, 2);
        push_pkt(1, 1, 2); push_pkt(1, 2, 2);
        wait_log(8, 100, "t2_wait");
        settle(2);
`ifdef COMPL_PRIORITY_EN
        exp_ord = '{0, 0, 1, 1};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        order.delete();
        foreach (log_q[i]) if (log_q[i].b.data[47:40] == 8'd0) order.push_back(int'(log_q[i].b.data[63:56]));
        check("t2_npkts", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("t2_order", order[i], exp_ord[i]);
        check("t2_cnt0", pkt_cnt0, 4'd2);
        check("t2_cnt1", pkt_cnt1, 4'd2);

        // T3: completer has 3 TLPs queued, requester 1
        do_reset();
        push_pkt(0, 1, 2); push_pkt(0, 2, 2); push_pkt(0, 3, 2);
        push_pkt(1, 1, 2);
        wait_log(8, 100, "t3_wait");
        settle(2);
`ifdef COMPL_PRIORITY_EN
        exp_ord = '{0, 0, 0, 1};
`else
        exp_ord = '{0, 1, 0, 0};
`endif
        order.delete();
        foreach (log_q[i]) if (log_q[i].b.data[47:40] == 8'd0) order.push_back(int'(log_q[i].b.data[63:56]));
        check("t3_npkts", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) check("t3_order", order[i], exp_ord[i]);

        // T4: tready toggling during a 4-beat port-1 TLP
        do_reset();
        in0_rdy_seen = 0;
        stalls = 0;
        tready_mode = 1;
        push_pkt(1, 7, 4);
        wait_log(4, 100, "t4_wait");
        settle(3);
        tready_mode = 0;
        check("t4_nbeats", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) check("t4_data", log_q[i].b.data, bdat(1, 7, i));
        check("t4_in0_tready", in0_rdy_seen, 0);
        check("t4_stalls_seen", (stalls > 0), 1'b1);
        check("t4_cnt1", pkt_cnt1, 4'd1);

        // T5: turnoff requested mid-packet
        do_reset();
        push_pkt(0, 3, 4);
        wait_log(1, 50, "t5_first");
        cfg_to_turnoff = 1'b1;
        wait_log(4, 50, "t5_wait");
        settle(4);
        check("t5_nbeats", log_q.size(), 4);
        last_cyc = (log_q.size() >= 4) ? log_q[3].cyc : -100;
        check("t5_ok_cycle", ok_rise, last_cyc + 2);
        check("t5_cnt0", pkt_cnt0, 4'd1);
        push_pkt(1, 4, 1);
        settle(4);
        check("t5_no_grant", log_q.size(), 4);
        check("t5_ok_held", cfg_turnoff_ok, 1'b1);
        cfg_to_turnoff = 1'b0;
        settle(1);
        check("t5_ok_drop", cfg_turnoff_ok, 1'b0);
        wait_log(5, 20, "t5_resume");
        if (log_q.size() >= 5) check("t5_resume_data", log_q[4].b.data, bdat(1, 4, 0));

        // T6: reset mid-packet, then counter wrap
        do_reset();
        push_pkt(0, 5, 4);
        wait_log(2, 50, "t6_wait");
        sys_rst_n = 1'b0;
        q0.delete();
        @(posedge user_clk);
        @(negedge user_clk);
        check("t6_tvalid", {s_axis_tx_tvalid, s_axis_tx_tlast}, 2'b00);
        check("t6_tdata", s_axis_tx_tdata, 64'h0);
        check("t6_tready", {in1_tready, in0_tready}, 2'b00);
        check("t6_cnt", {pkt_cnt1, pkt_cnt0}, 8'h00);
        @(posedge user_clk); #1;
        sys_rst_n = 1'b1;
        log_q.delete();
        for (int i = 0; i < 15; i++) push_pkt(0, i, 1);
        wait_log(15, 100, "t6_fill");
        settle(2);
        check("t6_cnt0_max", pkt_cnt0, 4'hF);
        push_pkt(0, 15, 1);
        wait_log(16, 20, "t6_wrap");
        settle(2);
        check("t6_cnt0_wrap", pkt_cnt0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
